// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared state/class encodings and default widths for the multicycle control unit
package mc_ctrl_pkg;
    localparam int ALU_OP_W_DEF    = 4;
    localparam int SHIFT_OP_W_DEF  = 3;
    localparam int MEM_TIMEOUT_DEF = 15;
    localparam int CNT_W           = 8;
    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_READ   = 4'd3,
        ST_EXEC   = 4'd4,
        ST_WB     = 4'd5,
        ST_MEM    = 4'd6,
        ST_MEM_WB = 4'd7,
        ST_BRANCH = 4'd8,
        ST_ABORT  = 4'd9
    } state_t;
    typedef enum logic [1:0] {
        CLS_DP     = 2'b00,
        CLS_LOAD   = 2'b01,
        CLS_STORE  = 2'b10,
        CLS_BRANCH = 2'b11
    } cls_t;
endpackage

// File: rtl/mem_timeout_counter.sv
// mem_timeout_counter: counts stalled memory cycles; hit marks the last stall cycle allowed
module mem_timeout_counter
    import mc_ctrl_pkg::*;
#(
    parameter int LIMIT = MEM_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic hit
);
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable)
            cnt <= cnt + 1'b1;
    end
    // enable already excludes ack cycles, so an ack in the final cycle wins
    assign hit = enable && (cnt == CNT_W'(LIMIT - 1));
endmodule

// File: rtl/mc_control_unit.sv
// mc_control_unit: multicycle datapath sequencer; outputs are registered from the next state
module mc_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int ALU_OP_W    = ALU_OP_W_DEF,
    parameter int SHIFT_OP_W  = SHIFT_OP_W_DEF,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ir_valid,
    input  logic                  cond_pass,
    input  logic [1:0]            instr_class,
    input  logic                  rm_imm_s,
    input  logic [1:0]            rs_imm_s,
    input  logic [SHIFT_OP_W-1:0] shift_op,
    input  logic [ALU_OP_W-1:0]   alu_op,
    input  logic                  s_bit,
    input  logic                  link,
    input  logic                  mem_ack,
    output logic                  write_pc,
    output logic                  write_ir,
    output logic                  write_reg,
    output logic [2:0]            ld_abc,
    output logic                  lf,
    output logic                  s_ctrl,
    output logic                  rm_imm_s_ctrl,
    output logic [1:0]            rs_imm_s_ctrl,
    output logic [SHIFT_OP_W-1:0] shift_op_ctrl,
    output logic [ALU_OP_W-1:0]   alu_op_ctrl,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic                  pc_src,
    output logic                  reg_dst_lr,
    output logic                  abort,
    output logic [3:0]            state_o
);
    state_t     state, nxt;
    cls_t       cls_q;
    logic       link_q, hit;
    logic       write_pc_d, write_ir_d, write_reg_d, lf_d, mem_req_d, mem_we_d;
    logic       pc_src_d, reg_dst_lr_d, abort_d;
    logic [2:0] ld_abc_d;

    mem_timeout_counter #(.LIMIT(MEM_TIMEOUT)) u_wait_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (state != ST_MEM),
        .enable (state == ST_MEM && !mem_ack),
        .hit    (hit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= ST_IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:   nxt = ST_FETCH;
            ST_FETCH:  nxt = ir_valid ? ST_DECODE : ST_FETCH;
            ST_DECODE: nxt = cond_pass ? ST_READ : ST_FETCH;
            ST_READ:   nxt = ST_EXEC;
            ST_EXEC:   nxt = cls_q == CLS_DP ? ST_WB : cls_q == CLS_BRANCH ? ST_BRANCH : ST_MEM;
            ST_MEM:    nxt = mem_ack ? (cls_q == CLS_LOAD ? ST_MEM_WB : ST_FETCH) : hit ? ST_ABORT : ST_MEM;
            default:   nxt = ST_FETCH;
        endcase
    end

    // cls_q/link_q are captured on EXEC entry, so lf must look at the live class
    always_comb begin
        write_pc_d   = nxt == ST_DECODE || nxt == ST_BRANCH;
        write_ir_d   = nxt == ST_DECODE;
        write_reg_d  = nxt == ST_WB || nxt == ST_MEM_WB || (nxt == ST_BRANCH && link_q);
        ld_abc_d     = {3{nxt == ST_READ}};
        lf_d         = nxt == ST_EXEC && instr_class == CLS_DP;
        mem_req_d    = nxt == ST_MEM;
        mem_we_d     = nxt == ST_MEM && cls_q == CLS_STORE;
        pc_src_d     = nxt == ST_BRANCH;
        reg_dst_lr_d = nxt == ST_BRANCH && link_q;
        abort_d      = nxt == ST_ABORT;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            write_pc      <= 1'b0;
            write_ir      <= 1'b0;
            write_reg     <= 1'b0;
            ld_abc        <= '0;
            lf            <= 1'b0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            pc_src        <= 1'b0;
            reg_dst_lr    <= 1'b0;
            abort         <= 1'b0;
            cls_q         <= CLS_DP;
            link_q        <= 1'b0;
            s_ctrl        <= 1'b0;
            rm_imm_s_ctrl <= 1'b0;
            rs_imm_s_ctrl <= '0;
            shift_op_ctrl <= '0;
            alu_op_ctrl   <= '0;
        end else begin
            write_pc   <= write_pc_d;
            write_ir   <= write_ir_d;
            write_reg  <= write_reg_d;
            ld_abc     <= ld_abc_d;
            lf         <= lf_d;
            mem_req    <= mem_req_d;
            mem_we     <= mem_we_d;
            pc_src     <= pc_src_d;
            reg_dst_lr <= reg_dst_lr_d;
            abort      <= abort_d;
            if (nxt == ST_EXEC) begin
                cls_q         <= cls_t'(instr_class);
                link_q        <= link;
                s_ctrl        <= s_bit;
                rm_imm_s_ctrl <= rm_imm_s;
                rs_imm_s_ctrl <= rs_imm_s;
                shift_op_ctrl <= shift_op;
                alu_op_ctrl   <= alu_op;
            end
        end
    end

    assign state_o = state;
endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit: directed instructions with a cycle-stamped expected-output scoreboard
module tb_mc_control_unit;
    localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DEC = 4'd2, S_READ = 4'd3, S_EXEC = 4'd4;
    localparam logic [3:0] S_WB = 4'd5, S_MEM = 4'd6, S_MWB = 4'd7, S_BR = 4'd8, S_AB = 4'd9;

    logic       clk = 1'b0, rst = 1'b0;
    logic       ir_valid = 1'b0, cond_pass = 1'b0, rm_imm_s = 1'b0, s_bit = 1'b0, link = 1'b0, mem_ack = 1'b0;
    logic [1:0] instr_class = 2'b00, rs_imm_s = 2'b00;
    logic [2:0] shift_op = 3'd0;
    logic [3:0] alu_op = 4'd0;
    logic       write_pc, write_ir, write_reg, lf, s_ctrl, rm_imm_s_ctrl, mem_req, mem_we, pc_src, reg_dst_lr, abort;
    logic [2:0] ld_abc, shift_op_ctrl;
    logic [1:0] rs_imm_s_ctrl;
    logic [3:0] alu_op_ctrl, state_o;

    mc_control_unit #(.ALU_OP_W(4), .SHIFT_OP_W(3), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .ir_valid(ir_valid), .cond_pass(cond_pass), .instr_class(instr_class),
        .rm_imm_s(rm_imm_s), .rs_imm_s(rs_imm_s), .shift_op(shift_op), .alu_op(alu_op), .s_bit(s_bit),
        .link(link), .mem_ack(mem_ack), .write_pc(write_pc), .write_ir(write_ir), .write_reg(write_reg),
        .ld_abc(ld_abc), .lf(lf), .s_ctrl(s_ctrl), .rm_imm_s_ctrl(rm_imm_s_ctrl), .rs_imm_s_ctrl(rs_imm_s_ctrl),
        .shift_op_ctrl(shift_op_ctrl), .alu_op_ctrl(alu_op_ctrl), .mem_req(mem_req), .mem_we(mem_we),
        .pc_src(pc_src), .reg_dst_lr(reg_dst_lr), .abort(abort), .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       wpc, wir, wreg;
        logic [2:0] abc;
        logic       lf, req, we, psrc, lr, ab;
        logic [3:0] alu;
        logic [2:0] sh;
        logic       s, rm;
        logic [1:0] rs;
    } obs_t;
    typedef struct {
        int    cyc;
        obs_t  o;
        string tag;
    } exp_t;

    exp_t       exp_q[$];
    int         cyc = 0, checks = 0, errors = 0;
    logic [3:0] c_alu = 4'd0;
    logic [2:0] c_sh = 3'd0;
    logic       c_s = 1'b0, c_rm = 1'b0;
    logic [1:0] c_rs = 2'd0;

    always @(posedge clk) cyc <= cyc + 1;

    // expected outputs for a state; f = lf in EXEC, mem_we in MEM, link in BRANCH
    function automatic obs_t mk(input logic [3:0] st, input logic f);
        obs_t o;
        o = '0;
        o.st = st;
        o.alu = c_alu;
        o.sh = c_sh;
        o.s = c_s;
        o.rm = c_rm;
        o.rs = c_rs;
        case (st)
            S_DEC:        begin o.wpc = 1'b1; o.wir = 1'b1; end
            S_READ:       o.abc = 3'b111;
            S_EXEC:       o.lf = f;
            S_WB, S_MWB:  o.wreg = 1'b1;
            S_MEM:        begin o.req = 1'b1; o.we = f; end
            S_BR:         begin o.wpc = 1'b1; o.psrc = 1'b1; o.wreg = f; o.lr = f; end
            S_AB:         o.ab = 1'b1;
            default:      ;
        endcase
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.st = state_o;
        o.wpc = write_pc;
        o.wir = write_ir;
        o.wreg = write_reg;
        o.abc = ld_abc;
        o.lf = lf;
        o.req = mem_req;
        o.we = mem_we;
        o.psrc = pc_src;
        o.lr = reg_dst_lr;
        o.ab = abort;
        o.alu = alu_op_ctrl;
        o.sh = shift_op_ctrl;
        o.s = s_ctrl;
        o.rm = rm_imm_s_ctrl;
        o.rs = rs_imm_s_ctrl;
        return o;
    endfunction

    task automatic expect_at(input int at, input logic [3:0] st, input logic f, input string tag);
        exp_t e;
        e.cyc = at;
        e.o = mk(st, f);
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic check_now(input string tag, input obs_t want);
        obs_t got;
        got = sample();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // any state beyond FETCH, or any enable, is a presented output to score
    always @(negedge clk) begin
        obs_t a;
        exp_t e;
        if (rst) begin
            a = sample();
            if (a.st > S_FETCH || a.wpc || a.wir || a.wreg || a.abc != 3'b000 || a.lf || a.req || a.ab) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious: got %h at cycle %0d want nothing", a, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (a !== e.o || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL %s: got %h at cycle %0d want %h at cycle %0d", e.tag, a, cyc, e.o, e.cyc);
                    end
                end
            end
        end
    end

    // called right after a posedge with the DUT in FETCH; returns 24 cycles later, back in FETCH
    task automatic run(input logic [1:0] cls, input logic cp, input logic lk, input logic [3:0] alu,
                       input logic [2:0] sh, input logic s, input logic rm, input logic [1:0] rs,
                       input int ack_k, input string nm);
        int b;
        instr_class = cls;
        cond_pass = cp;
        link = lk;
        alu_op = alu;
        shift_op = sh;
        s_bit = s;
        rm_imm_s = rm;
        rs_imm_s = rs;
        ir_valid = 1'b1;
        b = cyc;
        expect_at(b + 1, S_DEC, 1'b0, nm);
        if (cp) begin
            expect_at(b + 2, S_READ, 1'b0, nm);
            c_alu = alu;
            c_sh = sh;
            c_s = s;
            c_rm = rm;
            c_rs = rs;
            expect_at(b + 3, S_EXEC, cls == 2'b00, nm);
            case (cls)
                2'b00: expect_at(b + 4, S_WB, 1'b0, nm);
                2'b11: expect_at(b + 4, S_BR, lk, nm);
                default:
                    for (int k = 4; k < 19; k++) begin
                        expect_at(b + k, S_MEM, cls == 2'b10, nm);
                        if (k == ack_k) begin
                            if (cls == 2'b01) expect_at(b + k + 1, S_MWB, 1'b0, nm);
                            break;
                        end
                        if (k == 18) expect_at(b + k + 1, S_AB, 1'b0, nm);
                    end
            endcase
        end
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk);
            #1;
            ir_valid = 1'b0;
            mem_ack = (k == ack_k);
        end
        mem_ack = 1'b0;
    endtask

    initial begin
        int b;
        ir_valid = 1'b1;
        cond_pass = 1'b1;
        alu_op = 4'hC;
        mem_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_now("reset_hold", '0);
        ir_valid = 1'b0;
        mem_ack = 1'b0;
        #3 rst = 1'b1;
        #1 check_now("idle_after_release", mk(S_IDLE, 1'b0));
        @(posedge clk);
        #1 check_now("fetch_after_idle", mk(S_FETCH, 1'b0));

        run(2'b00, 1'b1, 1'b0, 4'h4, 3'h5, 1'b1, 1'b1, 2'b10, 0,  "dp");
        run(2'b00, 1'b0, 1'b0, 4'h9, 3'h1, 1'b0, 1'b0, 2'b01, 0,  "dp_cond_fail");
        run(2'b01, 1'b1, 1'b0, 4'hA, 3'h2, 1'b0, 1'b1, 2'b11, 6,  "load_ack3");
        run(2'b10, 1'b1, 1'b0, 4'h3, 3'h7, 1'b1, 1'b0, 2'b00, 0,  "store_timeout");
        run(2'b10, 1'b1, 1'b0, 4'h5, 3'h4, 1'b0, 1'b1, 2'b01, 18, "store_ack_at_limit");
        run(2'b11, 1'b1, 1'b1, 4'hF, 3'h0, 1'b1, 1'b1, 2'b10, 0,  "bl");
        run(2'b11, 1'b1, 1'b0, 4'h2, 3'h6, 1'b0, 1'b0, 2'b11, 0,  "b");
        run(2'b11, 1'b0, 1'b1, 4'h7, 3'h3, 1'b1, 1'b0, 2'b01, 0,  "bl_cond_fail");
        run(2'b01, 1'b1, 1'b0, 4'h6, 3'h1, 1'b1, 1'b1, 2'b00, 4,  "load_ack1");

        instr_class = 2'b10;
        cond_pass = 1'b1;
        link = 1'b0;
        alu_op = 4'hB;
        shift_op = 3'h2;
        s_bit = 1'b1;
        rm_imm_s = 1'b0;
        rs_imm_s = 2'b11;
        ir_valid = 1'b1;
        b = cyc;
        expect_at(b + 1, S_DEC, 1'b0, "rst_mem");
        expect_at(b + 2, S_READ, 1'b0, "rst_mem");
        c_alu = 4'hB;
        c_sh = 3'h2;
        c_s = 1'b1;
        c_rm = 1'b0;
        c_rs = 2'b11;
        expect_at(b + 3, S_EXEC, 1'b0, "rst_mem");
        expect_at(b + 4, S_MEM, 1'b1, "rst_mem");
        @(posedge clk);
        #1 ir_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b0;
        #1 check_now("async_reset_in_mem", '0);
        c_alu = 4'h0;
        c_sh = 3'h0;
        c_s = 1'b0;
        c_rm = 1'b0;
        c_rs = 2'b00;
        #3 rst = 1'b1;
        #1 check_now("idle_after_mid_reset", mk(S_IDLE, 1'b0));
        @(posedge clk);
        #1 check_now("fetch_after_mid_reset", mk(S_FETCH, 1'b0));

        run(2'b00, 1'b1, 1'b0, 4'h1, 3'h3, 1'b0, 1'b1, 2'b01, 0, "dp_after_reset");

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
